fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter DPW, default 32, meaning instruction/address width.
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning first fetch address after reset.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on posedge clk.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port stallF  input  1  hazard stall; blocks new requests.
REQ-006 SHALL have port stallD  input  1  decode register holding; blocks buffer pop.
REQ-007 SHALL have port pc_srcE  input  1  taken branch/jump redirect from execute.
REQ-008 SHALL have port pc_targetE  input  DPW  redirect target address.
REQ-009 SHALL have port imem_req  output  1  instruction memory request valid.
REQ-010 SHALL have port imem_addr  output  DPW  request address.
REQ-011 SHALL have port imem_ready  input  1  memory accepts request this cycle.
REQ-012 SHALL have port imem_rvalid  input  1  in-order response valid.
REQ-013 SHALL have port imem_rdata  input  DPW  response instruction word.
REQ-014 SHALL have port instr  output  DPW  head instruction, to decode stage register.
REQ-015 SHALL have port pcF  output  DPW  address of head instruction.
REQ-016 SHALL have port pcplus4F  output  DPW  pcF + 4.
REQ-017 SHALL have port validF  output  1  head entry valid.

Function
REQ-018 SHALL hold a fetch PC register (next request address); imem_addr SHALL equal it, bits [1:0] always 0.
REQ-019 SHALL assert imem_req when !rst, !stallF, !pc_srcE, and outstanding + buffered < 2 (credit limit 2).
REQ-020 SHALL count a request accepted only when imem_req && imem_ready; on acceptance PC <= PC + 4 (mod 2^DPW, wrap at 0xFFFF_FFFC -> 0) and the address is pushed onto a 2-entry in-flight address queue.
REQ-021 SHALL keep imem_req/imem_addr stable while imem_req && !imem_ready unless stallF, pc_srcE or rst intervenes.
REQ-022 SHALL, on imem_rvalid with discard count 0, push {queued address, imem_rdata} into a 2-entry instruction buffer and pop the address queue.
REQ-023 SHALL, on imem_rvalid with discard count > 0, drop the response, pop the address queue, decrement discard count.
REQ-024 SHALL drive instr/pcF from buffer head, validF = buffer non-empty; when empty instr = 32'h0000_0013 (NOP), pcF = 0, validF = 0.
REQ-025 SHALL pop the head when validF && !stallD; push and pop in same cycle SHALL leave count unchanged.
REQ-026 SHALL, on pc_srcE: PC <= {pc_targetE[DPW-1:2],2'b00}; instruction buffer emptied; discard count <= outstanding requests after this cycle's response (responses for all earlier requests dropped); no request issued that cycle.
REQ-027 SHALL give pc_srcE priority over stallF and stallD; rst priority over everything.
REQ-028 SHALL never overflow buffer or address queue (guaranteed by REQ-019); response with empty address queue is illegal input and SHALL be ignored.
REQ-029 SHALL have latency: request at cycle N, response at N+k (k >= 1) -> validF high at N+k+1.

Reset
REQ-030 SHALL on rst: PC <= RESET_PC, buffer/address queue empty, outstanding = 0, discard = 0, imem_req = 0, validF = 0, instr = 32'h0000_0013, pcF = 0, pcplus4F = 4.
REQ-031 SHALL treat responses arriving after a mid-operation rst as discarded (outstanding requests cleared; memory is reset alongside).

Verification
REQ-032 Reset release, imem_ready=1, 1-cycle memory: requests at 0x0,0x4,0x8; validF first high 2 cycles after first request, pcF=0x0, instr=mem[0].
REQ-033 stallD=1 for 4 cycles: buffer fills to 2, imem_req drops, no lost or duplicated instruction when stallD releases.
REQ-034 pc_srcE=1, pc_targetE=0x0000_0102 with 2 requests in flight: both responses dropped, next imem_addr=0x0000_0100, validF=0 until its response.
REQ-035 imem_ready=0 for 3 cycles with stallF toggling: imem_addr held, exactly one acceptance per address.
REQ-036 PC=0xFFFF_FFFC accepted: next imem_addr=0x0000_0000, pcplus4F of that entry=0x0000_0000.
REQ-037 rst asserted with responses pending: all outputs at reset values next cycle; stale responses not delivered.

Source files
------------

// File: rtl/fetch_stage.sv
// fetch_stage: credit-limited instruction fetch with an in-flight address queue,
// a 2-entry instruction buffer and redirect-driven discard of stale responses.
module fetch_stage #(
    parameter int DPW = 32,
    parameter logic [DPW-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           stallF,
    input  logic           stallD,
    input  logic           pc_srcE,
    input  logic [DPW-1:0] pc_targetE,
    output logic           imem_req,
    output logic [DPW-1:0] imem_addr,
    input  logic           imem_ready,
    input  logic           imem_rvalid,
    input  logic [DPW-1:0] imem_rdata,
    output logic [DPW-1:0] instr,
    output logic [DPW-1:0] pcF,
    output logic [DPW-1:0] pcplus4F,
    output logic           validF
);
    logic [DPW-1:0] pc;
    logic [DPW-1:0] aq [2];
    logic [DPW-1:0] bpc [2];
    logic [DPW-1:0] bin [2];
    logic [1:0] aq_cnt, b_cnt, disc;
    logic accept, resp, keep, pop, aq_wi, b_wi;

    // Outstanding plus buffered never exceeds 2, so neither queue can overflow.
    assign imem_req = !rst && !stallF && !pc_srcE && ({1'b0, aq_cnt} + {1'b0, b_cnt} < 3'd2);
    assign imem_addr = pc;
    assign accept = imem_req && imem_ready;
    assign resp = imem_rvalid && aq_cnt != 2'd0;
    assign keep = resp && disc == 2'd0 && !pc_srcE;
    assign validF = b_cnt != 2'd0;
    assign pop = validF && !stallD && !pc_srcE;
    assign aq_wi = aq_cnt[0] & ~resp;
    assign b_wi = b_cnt[0] & ~pop;
    assign instr = validF ? bin[0] : DPW'(32'h0000_0013);
    assign pcF = validF ? bpc[0] : '0;
    assign pcplus4F = pcF + DPW'(4);

    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= {RESET_PC[DPW-1:2], 2'b00};
            aq_cnt <= '0;
            b_cnt <= '0;
            disc <= '0;
        end else begin
            if (pc_srcE) pc <= {pc_targetE[DPW-1:2], 2'b00};
            else if (accept) pc <= pc + DPW'(4);
            aq_cnt <= aq_cnt + 2'(accept) - 2'(resp);
            b_cnt <= pc_srcE ? 2'd0 : b_cnt + 2'(keep) - 2'(pop);
            // Every request still in flight after a redirect belongs to the old path.
            if (pc_srcE) disc <= aq_cnt - 2'(resp);
            else if (resp && disc != 2'd0) disc <= disc - 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (resp) aq[0] <= aq[1];
        if (accept) aq[aq_wi] <= pc;
        if (pop) begin
            bpc[0] <= bpc[1];
            bin[0] <= bin[1];
        end
        if (keep) begin
            bpc[b_wi] <= aq[0];
            bin[b_wi] <= imem_rdata;
        end
    end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed vector table, hand sequences for wrap and reset,
// then randomized traffic against a queue-based reference model.
module tb_fetch_stage;
    localparam logic [31:0] NOP = 32'h0000_0013;
    logic clk = 1'b0;
    logic rst, stallF, stallD, pc_srcE, imem_ready, imem_rvalid, imem_req, validF;
    logic [31:0] pc_targetE, imem_addr, imem_rdata, instr, pcF, pcplus4F;
    int vecs = 0, errs = 0, cyc = 0, last_due = 0;

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk(clk), .rst(rst), .stallF(stallF), .stallD(stallD),
        .pc_srcE(pc_srcE), .pc_targetE(pc_targetE),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .instr(instr), .pcF(pcF), .pcplus4F(pcplus4F), .validF(validF)
    );

    typedef struct {
        logic r, sf, sd, ps;
        logic [31:0] tg;
        logic rd, rv;
        logic [31:0] rdat;
        logic e_req;
        logic [31:0] e_addr;
        logic e_v;
        logic [31:0] e_pc, e_in;
    } vec_t;
    typedef struct { logic [31:0] a; int due; } mreq_t;
    typedef struct { logic [31:0] a; bit stale; } fl_t;
    typedef struct { logic [31:0] pc, ins; } be_t;

    vec_t tbl[13];
    mreq_t mq[$];
    fl_t inflight[$];
    be_t bq[$];
    logic [31:0] m_pc;

    function automatic logic [31:0] mem(logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hDEAD_BEEF;
    endfunction

    task automatic chk(string tag, string n, logic [31:0] a, logic [31:0] e);
        vecs++;
        if (a !== e) begin
            errs++;
            $display("FAIL %s %s: got %h expected %h", tag, n, a, e);
        end
    endtask

    task automatic step(logic r, logic sf, logic sd, logic ps, logic [31:0] tg,
                        logic rd, logic rv, logic [31:0] rdat);
        @(negedge clk);
        rst = r; stallF = sf; stallD = sd; pc_srcE = ps; pc_targetE = tg;
        imem_ready = rd; imem_rvalid = rv; imem_rdata = rdat;
        #2;
    endtask

    task automatic check_out(string tag, logic e_req, logic [31:0] e_addr, logic e_v,
                             logic [31:0] e_pc, logic [31:0] e_in);
        chk(tag, "imem_req", {31'd0, imem_req}, {31'd0, e_req});
        chk(tag, "imem_addr", imem_addr, e_addr);
        chk(tag, "validF", {31'd0, validF}, {31'd0, e_v});
        chk(tag, "pcF", pcF, e_pc);
        chk(tag, "instr", instr, e_in);
        chk(tag, "pcplus4F", pcplus4F, e_pc + 32'd4);
    endtask

    initial begin
        logic e_req, acc;
        logic [31:0] acc_a;
        fl_t f;
        rst = 1'b1; stallF = 1'b0; stallD = 1'b0; pc_srcE = 1'b0; pc_targetE = '0;
        imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        tbl = '{
            '{1'b1,1'b0,1'b0,1'b0,32'h0,  1'b0,1'b0,32'h0,         1'b0,32'h0,  1'b0,32'h0,  NOP},
            '{1'b0,1'b0,1'b0,1'b0,32'h0,  1'b1,1'b0,32'h0,         1'b1,32'h0,  1'b0,32'h0,  NOP},
            '{1'b0,1'b0,1'b0,1'b0,32'h0,  1'b1,1'b1,mem(32'h0),    1'b1,32'h4,  1'b0,32'h0,  NOP},
            '{1'b0,1'b0,1'b0,1'b0,32'h0,  1'b1,1'b1,mem(32'h4),    1'b0,32'h8,  1'b1,32'h0,  mem(32'h0)},
            '{1'b0,1'b0,1'b0,1'b0,32'h0,  1'b1,1'b0,32'h0,         1'b1,32'h8,  1'b1,32'h4,  mem(32'h4)},
            '{1'b0,1'b0,1'b0,1'b0,32'h0,  1'b1,1'b0,32'h0,         1'b1,32'hC,  1'b0,32'h0,  NOP},
            '{1'b0,1'b0,1'b0,1'b1,32'h102,1'b1,1'b1,mem(32'h8),    1'b0,32'h10, 1'b0,32'h0,  NOP},
            '{1'b0,1'b0,1'b0,1'b0,32'h0,  1'b0,1'b1,mem(32'hC),    1'b1,32'h100,1'b0,32'h0,  NOP},
            '{1'b0,1'b0,1'b0,1'b0,32'h0,  1'b1,1'b0,32'h0,         1'b1,32'h100,1'b0,32'h0,  NOP},
            '{1'b0,1'b0,1'b0,1'b0,32'h0,  1'b0,1'b1,mem(32'h100),  1'b1,32'h104,1'b0,32'h0,  NOP},
            '{1'b0,1'b0,1'b1,1'b0,32'h0,  1'b0,1'b0,32'h0,         1'b1,32'h104,1'b1,32'h100,mem(32'h100)},
            '{1'b0,1'b1,1'b0,1'b0,32'h0,  1'b1,1'b0,32'h0,         1'b0,32'h104,1'b1,32'h100,mem(32'h100)},
            '{1'b0,1'b0,1'b0,1'b0,32'h0,  1'b0,1'b0,32'h0,         1'b1,32'h104,1'b0,32'h0,  NOP}
        };
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 13; i++) begin
            step(tbl[i].r, tbl[i].sf, tbl[i].sd, tbl[i].ps, tbl[i].tg, tbl[i].rd, tbl[i].rv, tbl[i].rdat);
            check_out($sformatf("tbl%0d", i), tbl[i].e_req, tbl[i].e_addr, tbl[i].e_v, tbl[i].e_pc, tbl[i].e_in);
        end

        // Address wrap: entry at 0xFFFF_FFFC reports pcplus4F = 0
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b1, 1'b0, 32'h0);
        check_out("wrap0", 1'b0, 32'h0, 1'b0, 32'h0, NOP);
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        check_out("wrap1", 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, NOP);
        step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1, mem(32'hFFFF_FFFC));
        check_out("wrap2", 1'b1, 32'h0, 1'b0, 32'h0, NOP);
        step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        check_out("wrap3", 1'b1, 32'h0, 1'b1, 32'hFFFF_FFFC, mem(32'hFFFF_FFFC));

        // Reset with a buffered entry and a response pending
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1, mem(32'h0));
        step(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1, mem(32'h4));
        check_out("rst0", 1'b0, 32'h8, 1'b1, 32'h0, mem(32'h0));
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        check_out("rst1", 1'b0, 32'h0, 1'b0, 32'h0, NOP);
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, mem(32'h4));
        check_out("rst2", 1'b1, 32'h0, 1'b0, 32'h0, NOP);
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        check_out("rst3", 1'b1, 32'h0, 1'b0, 32'h0, NOP);

        // Randomized traffic with a variable-latency in-order memory
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        m_pc = 32'h0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            cyc++;
            rst = $urandom_range(199) == 0;
            stallF = $urandom_range(4) == 0;
            stallD = $urandom_range(2) == 0;
            pc_srcE = $urandom_range(15) == 0;
            pc_targetE = ($urandom_range(7) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
            imem_ready = $urandom_range(3) != 0;
            imem_rvalid = mq.size() > 0 && mq[0].due <= cyc;
            imem_rdata = imem_rvalid ? mem(mq[0].a) : $urandom;
            e_req = !rst && !stallF && !pc_srcE && (inflight.size() + bq.size() < 2);
            #2;
            if (bq.size() > 0) check_out("rand", e_req, m_pc, 1'b1, bq[0].pc, bq[0].ins);
            else check_out("rand", e_req, m_pc, 1'b0, 32'h0, NOP);
            acc = imem_req && imem_ready;
            acc_a = imem_addr;
            @(posedge clk);
            if (imem_rvalid) void'(mq.pop_front());
            if (acc) begin
                last_due = (cyc + int'($urandom_range(3, 1)) > last_due) ? cyc + int'($urandom_range(3, 1)) : last_due + 1;
                mq.push_back('{acc_a, last_due});
            end
            if (rst) begin
                mq.delete();
                last_due = 0;
                m_pc = 32'h0;
                inflight.delete();
                bq.delete();
            end else begin
                if (bq.size() > 0 && !stallD && !pc_srcE) void'(bq.pop_front());
                if (imem_rvalid && inflight.size() > 0) begin
                    f = inflight.pop_front();
                    if (!f.stale && !pc_srcE) bq.push_back('{f.a, imem_rdata});
                end
                if (pc_srcE) begin
                    foreach (inflight[k]) inflight[k].stale = 1'b1;
                    bq.delete();
                    m_pc = {pc_targetE[31:2], 2'b00};
                end else if (e_req && imem_ready) begin
                    inflight.push_back('{m_pc, 1'b0});
                    m_pc = m_pc + 32'd4;
                end
            end
        end
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
